fifo_stream_reader: RTL and testbench

Pop-side controller for the team's Synchronous_FIFO. It drains the FIFO through its push/pop interface and presents words as a valid/ready stream with frame framing (`out_last_o`). A 2-entry registered output buffer gives full throughput. The pop decision is registered, so there is no combinational path from `out_ready_i` to `fifo_pop_o`. It sits between Synchronous_FIFO and any downstream consumer (serializer, bus master).

---
 rtl/fifo_stream_reader.sv | 92 +++++++++
 tb/tb_fifo_stream_reader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Pop-side controller for Synchronous_FIFO: drains the FIFO into a 2-entry registered
// buffer and presents it as a valid/ready stream with frame framing on out_last_o.
module fifo_stream_reader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_pop_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  words_sent_o,
    output logic              busy_o
);

    localparam int unsigned FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FCNT_W-1:0] LAST_IDX = FCNT_W'(FRAME_LEN - 1);

    logic [1:0]        r_occ, w_occ_next;
    logic [DATA_W-1:0] r_data0, r_data1, w_data0_next, w_data1_next;
    logic              r_last0, r_last1, w_last0_next, w_last1_next;
    logic [FCNT_W-1:0] r_frame_cnt, w_frame_cnt_next;
    logic [CNT_W-1:0]  r_words_sent;
    logic              w_pop, w_deq, w_tag_last;
    logic [1:0]        w_occ_after_deq;

    // Pop depends only on registered occupancy, never on out_ready_i.
    assign w_pop           = enable_i & ~fifo_empty_i & (r_occ != 2'd2) & ~reset;
    assign w_deq           = (r_occ != 2'd0) & out_ready_i;
    assign w_tag_last      = (r_frame_cnt == LAST_IDX);
    assign w_occ_after_deq = r_occ - 2'(w_deq);

    always_comb begin
        w_data0_next     = r_data0;
        w_data1_next     = r_data1;
        w_last0_next     = r_last0;
        w_last1_next     = r_last1;
        w_frame_cnt_next = r_frame_cnt;
        if (w_deq) begin
            w_data0_next = r_data1;
            w_last0_next = r_last1;
        end
        if (w_pop) begin
            // New word lands directly behind whatever survives this edge's dequeue.
            if (w_occ_after_deq == 2'd0) begin
                w_data0_next = fifo_data_i;
                w_last0_next = w_tag_last;
            end else begin
                w_data1_next = fifo_data_i;
                w_last1_next = w_tag_last;
            end
            w_frame_cnt_next = w_tag_last ? '0 : r_frame_cnt + FCNT_W'(1);
        end
        w_occ_next = w_occ_after_deq + 2'(w_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ        <= 2'd0;
            r_data0      <= '0;
            r_data1      <= '0;
            r_last0      <= 1'b0;
            r_last1      <= 1'b0;
            r_frame_cnt  <= '0;
            r_words_sent <= '0;
        end else begin
            r_occ       <= w_occ_next;
            r_data0     <= w_data0_next;
            r_data1     <= w_data1_next;
            r_last0     <= w_last0_next;
            r_last1     <= w_last1_next;
            r_frame_cnt <= w_frame_cnt_next;
            if (w_deq) begin
                r_words_sent <= r_words_sent + CNT_W'(1);
            end
        end
    end

    assign fifo_pop_o   = w_pop;
    assign out_valid_o  = (r_occ != 2'd0);
    assign out_data_o   = r_data0;
    assign out_last_o   = r_last0;
    assign busy_o       = (r_occ != 2'd0);
    assign words_sent_o = r_words_sent;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: a queue-based FIFO model feeds the reader; expected words and frame
// tags come from push order, and a negedge monitor compares every presented word.
module tb_fifo_stream_reader;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, ready;
    logic       fifo_empty, fifo_pop, out_valid, out_last, busy;
    logic [7:0] fifo_data, out_data;
    logic [15:0] words_sent;

    logic       fifo2_empty, fifo2_pop, out2_valid, out2_last, busy2;
    logic [7:0] fifo2_data, out2_data;
    logic [1:0] words_sent2;
    logic       tie1 = 1'b1;

    logic [7:0] fq[$];
    logic [7:0] fq2[$];
    exp_t       exp_q[$];
    logic [7:0] exp2_q[$];

    int unsigned k = 0;
    int          checks = 0;
    int          errors = 0;
    int          occ_m = 0;
    int          pops_total = 0;
    logic [15:0] exp_sent = '0;
    logic [1:0]  exp_sent2 = '0;
    bit          pend, pend2;

    fifo_stream_reader #(.DATA_W(8), .FRAME_LEN(4), .CNT_W(16)) u_dut (
        .clk          (clk),
        .reset        (rst),
        .enable_i     (enable),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_pop_o   (fifo_pop),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .out_ready_i  (ready),
        .words_sent_o (words_sent),
        .busy_o       (busy)
    );

    fifo_stream_reader #(.DATA_W(8), .FRAME_LEN(1), .CNT_W(2)) u_dut2 (
        .clk          (clk),
        .reset        (rst),
        .enable_i     (tie1),
        .fifo_empty_i (fifo2_empty),
        .fifo_data_i  (fifo2_data),
        .fifo_pop_o   (fifo2_pop),
        .out_valid_o  (out2_valid),
        .out_data_o   (out2_data),
        .out_last_o   (out2_last),
        .out_ready_i  (tie1),
        .words_sent_o (words_sent2),
        .busy_o       (busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void upd();
        fifo_empty  = (fq.size() == 0);
        fifo_data   = fifo_empty ? 8'h00 : fq[0];
        fifo2_empty = (fq2.size() == 0);
        fifo2_data  = fifo2_empty ? 8'h00 : fq2[0];
    endfunction

    task automatic push(input logic [7:0] d);
        exp_t e;
        e.d = d;
        e.l = ((k % 4) == 3);
        k++;
        fq.push_back(d);
        exp_q.push_back(e);
        upd();
    endtask

    task automatic push2(input logic [7:0] d);
        fq2.push_back(d);
        exp2_q.push_back(d);
        upd();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst valid", 32'(out_valid), 0);
        chk("rst data", 32'(out_data), 0);
        chk("rst last", 32'(out_last), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst pop", 32'(fifo_pop), 0);
        chk("rst sent", 32'(words_sent), 0);
        chk("rst valid2", 32'(out2_valid), 0);
        fq.delete();
        fq2.delete();
        exp_q.delete();
        exp2_q.delete();
        k = 0;
        occ_m = 0;
        exp_sent = '0;
        exp_sent2 = '0;
        upd();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        chk("drain within budget", 32'(n < budget), 1);
    endtask

    // FIFO model: pop decision sampled mid-cycle, head consumed just after the edge.
    always @(negedge clk) begin
        pend  = fifo_pop;
        pend2 = fifo2_pop;
    end

    always @(posedge clk) begin
        #1;
        if (pend && fq.size() > 0) void'(fq.pop_front());
        if (pend2 && fq2.size() > 0) void'(fq2.pop_front());
        pend  = 1'b0;
        pend2 = 1'b0;
        upd();
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk("words_sent", 32'(words_sent), 32'(exp_sent));
            chk("pop rule", 32'(fifo_pop), 32'(enable && !fifo_empty && occ_m != 2));
            chk("valid vs occupancy", 32'(out_valid), 32'(occ_m != 0));
            chk("busy vs occupancy", 32'(busy), 32'(occ_m != 0));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("stream data", 32'(out_data), 32'(exp_q[0].d));
                    chk("stream last", 32'(out_last), 32'(exp_q[0].l));
                    if (ready) void'(exp_q.pop_front());
                end
            end
            if (out_valid && ready) exp_sent++;
            if (fifo_pop) pops_total++;
            occ_m = occ_m + (fifo_pop ? 1 : 0) - ((out_valid && ready) ? 1 : 0);

            chk("words_sent2", 32'(words_sent2), 32'(exp_sent2));
            if (out2_valid) begin
                if (exp2_q.size() == 0) begin
                    chk("unexpected word2", 32'(out2_data), 32'hFFFF_FFFF);
                end else begin
                    chk("stream2 data", 32'(out2_data), 32'(exp2_q.pop_front()));
                    chk("stream2 last", 32'(out2_last), 1);
                end
                exp_sent2++;
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] vpat;
        logic [7:0] t1w [4];
        int p0;
        t1w[0] = 8'h24; t1w[1] = 8'h81; t1w[2] = 8'h09; t1w[3] = 8'h63;
        rst = 1'b1;
        enable = 1'b0;
        ready = 1'b0;
        upd();
        #1;
        chk("init valid", 32'(out_valid), 0);
        chk("init pop", 32'(fifo_pop), 0);
        repeat (2) tick();
        rst = 1'b0;

        // FRAME_LEN=1, CNT_W=2 instance: every word last, counter wraps 3 -> 0.
        for (int i = 0; i < 5; i++) push2(8'(8'h10 + i));
        repeat (10) tick();
        chk("dut2 drained", 32'(exp2_q.size()), 0);
        chk("dut2 sent wrap", 32'(words_sent2), 1);

        // Four words, full throughput, 1-cycle latency.
        enable = 1'b1;
        ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push(t1w[i]);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vpat[i] = out_valid;
        end
        chk("t1 valid pattern", 32'(vpat), 32'(6'b011110));
        chk("t1 sent", 32'(words_sent), 4);
        chk("t1 busy", 32'(busy), 0);
        chk("t1 fifo empty", 32'(fifo_empty), 1);
        tick();

        // Backpressure: only two words buffered.
        ready = 1'b0;
        tick();
        p0 = pops_total;
        for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
        repeat (8) tick();
        chk("t2 pops under backpressure", 32'(pops_total - p0), 2);
        chk("t2 pop held low", 32'(fifo_pop), 0);
        ready = 1'b1;
        drain(40);

        // Toggling ready.
        for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
        for (int i = 0; i < 24; i++) begin
            ready = (i % 2 == 0);
            tick();
        end
        ready = 1'b1;
        drain(40);
        chk("t3 total sent", 32'(words_sent), 18);

        // Enable gap mid-frame: frame position is retained.
        do_reset();
        enable = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) push(8'(8'h30 + i));
        p0 = pops_total;
        enable = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        repeat (3) tick();
        chk("t4 pops before gap", 32'(pops_total - p0), 2);
        push(8'h33);
        push(8'h34);
        enable = 1'b1;
        drain(40);

        // Reset with two buffered words mid-frame.
        ready = 1'b0;
        p0 = pops_total;
        for (int i = 0; i < 3; i++) push(8'(8'h50 + i));
        repeat (4) tick();
        chk("t5 buffer full", 32'(pops_total - p0), 2);
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
        drain(40);
        chk("t5 sent after reset", 32'(words_sent), 4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            ready  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1 && fq.size() < 8) push(8'($urandom));
            tick();
        end
        enable = 1'b1;
        ready = 1'b1;
        drain(60);
        chk("random sent", 32'(words_sent), 32'(exp_sent));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
